move_vote_filter: RTL and testbench
===================================

// Module: move_vote_filter
// PURPOSE
//  Downstream of the image-processing unit: consumes the per-frame cell location (loc) and
//  detection strobe (interrupt) and turns them into one debounced tic-tac-toe move.
//  A move is accepted only after HOLD_FRAMES consecutive detections agree on the same cell.
//  It is then held for the game controller under a valid/ack handshake.
//  A cooldown of COOLDOWN_FRAMES detections follows, so one held gesture cannot place two marks.
// PARAMETERS
//  HOLD_FRAMES      4   consecutive agreeing detections needed to accept a move (>=1)
//  COOLDOWN_FRAMES  8   detections ignored after an acknowledged move (0 = no cooldown)
//  MAX_CELL         8   highest valid cell index; loc > MAX_CELL means "no hand / none"
// PORTS
//  iCLK         in   1  pixel clock, same domain as the image-processing unit
//  iRST         in   1  synchronous, active-high reset
//  iLoc         in   4  cell location from detector; sampled only on a detection event
//  iInt         in   1  detection strobe; rising edge = one detection event (level or pulse OK)
//  iMove_Ack    in   1  game controller accepts oMove; sampled while oMove_Valid=1
//  oMove        out  4  accepted cell index, stable while oMove_Valid=1
//  oMove_Valid  out  1  move pending for controller
//  oCand        out  4  current candidate cell (debug/LED)
//  oCount       out  4  agreeing-detection count for candidate (debug)
//  oBusy        out  1  high in PEND or COOLDOWN
// BEHAVIOUR
//  - Event detect: int_d <= iInt; ev = iInt & ~int_d. iLoc is captured in the ev cycle. All outputs registered.
//  - Reset (any state, mid-operation included): state=IDLE, int_d=0, oMove=0, oMove_Valid=0,
//    oCand=4'hF, oCount=0, oBusy=0, cooldown counter=0. An iInt already high at reset release
//    gives no event until it falls and rises again.
//  - valid(l) = (l <= MAX_CELL).
//  - IDLE: ev & valid -> oCand=iLoc, oCount=1; go TRACK, or PEND if HOLD_FRAMES==1.
//    ev & !valid -> stay IDLE.
//  - TRACK:
//      ev & iLoc==oCand -> oCount++; when the new count == HOLD_FRAMES: go PEND,
//        oMove=oCand, oMove_Valid=1.
//      ev & valid & iLoc!=oCand -> oCand=iLoc, oCount=1 (restart on new cell).
//      ev & !valid -> IDLE, oCand=4'hF, oCount=0.
//  - PEND: oMove/oMove_Valid held; events ignored.
//      iMove_Ack -> oMove_Valid=0 next cycle, oCount=0, oCand=4'hF; go COOLDOWN,
//        or IDLE if COOLDOWN_FRAMES==0.
//      ack and ev in same cycle: ack taken; that ev is not counted toward cooldown.
//      iMove_Ack while oMove_Valid=0 is ignored in every state.
//  - COOLDOWN: each ev (valid or not) increments cooldown counter; on reaching
//    COOLDOWN_FRAMES -> IDLE, counter=0.
//  - Latency: oMove_Valid rises 1 cycle after the iInt rising edge that completes the hold.
//  - Counters: oCount saturates at HOLD_FRAMES (never wraps); cooldown counter width
//    $clog2(COOLDOWN_FRAMES+1), no wrap.
//  - No move is ever lost or duplicated: at most one oMove_Valid assertion per accepted hold.
// TESTING
//  1 Reset, then 4 iInt pulses with iLoc=5 -> oMove_Valid=1, oMove=5 one cycle after 4th rise; oBusy=1.
//  2 Pulses loc 3,3,7,7,7,7 -> only move 7 reported; oCount goes 1,2,1,2,3,4.
//  3 Pulses loc 2,2,15,2,2,2,2 -> invalid loc returns to IDLE; move 2 after the last 4 pulses only.
//  4 Move pending, 6 further pulses, no ack -> oMove_Valid stays 1, oMove unchanged; ack -> drops next cycle.
//  5 After ack, 8 pulses loc=4 -> nothing; then 4 more loc=4 -> move 4 reported
//    (ack coincident with a pulse: cooldown needs 8 further pulses).
//  6 iRST asserted for 1 cycle in TRACK (oCount=3) and in PEND -> all outputs at reset values next cycle;
//    iInt held high across reset produces no event.

Source files
------------

// File: rtl/move_vote_filter.sv
// Debounces per-frame cell detections into single tic-tac-toe moves: a cell must be seen on
// HOLD_FRAMES consecutive detections, is then held under valid/ack, and is followed by a cooldown.
module move_vote_filter #(
  parameter int HOLD_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAX_CELL        = 8
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [3:0] iLoc,
  input  logic       iInt,
  input  logic       iMove_Ack,
  output logic [3:0] oMove,
  output logic       oMove_Valid,
  output logic [3:0] oCand,
  output logic [3:0] oCount,
  output logic       oBusy
);

  localparam int         CW      = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [3:0] NONE    = 4'hF;
  localparam logic [3:0] HOLD    = 4'(HOLD_FRAMES);
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRACK    = 2'd1,
    S_PEND     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_int_d;
  logic          r_armed;
  logic [3:0]    r_move;
  logic          r_move_valid;
  logic [3:0]    r_cand;
  logic [3:0]    r_count;
  logic          r_busy;
  logic [CW-1:0] r_cd_cnt;

  logic          w_ev;
  logic          w_loc_valid;
  logic          w_same;
  logic [3:0]    w_count_next;
  logic [CW-1:0] w_cd_next;

  // r_armed blocks a level that was already high when reset released from looking like an edge.
  assign w_ev         = iInt & ~r_int_d & r_armed;
  assign w_loc_valid  = (iLoc <= 4'(MAX_CELL));
  assign w_same       = (iLoc == r_cand);
  assign w_count_next = (r_count == HOLD) ? r_count : r_count + 4'd1;
  assign w_cd_next    = r_cd_cnt + CW'(1);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= S_IDLE;
      r_int_d      <= 1'b0;
      r_armed      <= 1'b0;
      r_move       <= 4'd0;
      r_move_valid <= 1'b0;
      r_cand       <= NONE;
      r_count      <= 4'd0;
      r_busy       <= 1'b0;
      r_cd_cnt     <= '0;
    end else begin
      r_int_d <= iInt;
      if (!iInt) r_armed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_ev && w_loc_valid) begin
            r_cand  <= iLoc;
            r_count <= 4'd1;
            if (HOLD_FRAMES == 1) begin
              r_state      <= S_PEND;
              r_move       <= iLoc;
              r_move_valid <= 1'b1;
              r_busy       <= 1'b1;
            end else begin
              r_state <= S_TRACK;
            end
          end
        end

        S_TRACK: begin
          if (w_ev) begin
            if (!w_loc_valid) begin
              r_state <= S_IDLE;
              r_cand  <= NONE;
              r_count <= 4'd0;
            end else if (w_same) begin
              r_count <= w_count_next;
              if (w_count_next == HOLD) begin
                r_state      <= S_PEND;
                r_move       <= r_cand;
                r_move_valid <= 1'b1;
                r_busy       <= 1'b1;
              end
            end else begin
              // A different valid cell restarts the vote rather than dropping to IDLE.
              r_cand  <= iLoc;
              r_count <= 4'd1;
            end
          end
        end

        S_PEND: begin
          // Detections are ignored here, including one coincident with the ack.
          if (iMove_Ack && r_move_valid) begin
            r_move_valid <= 1'b0;
            r_count      <= 4'd0;
            r_cand       <= NONE;
            r_cd_cnt     <= '0;
            if (COOLDOWN_FRAMES == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_COOLDOWN;
              r_busy  <= 1'b1;
            end
          end
        end

        S_COOLDOWN: begin
          if (w_ev) begin
            if (w_cd_next == CD_LAST) begin
              r_state  <= S_IDLE;
              r_cd_cnt <= '0;
              r_busy   <= 1'b0;
            end else begin
              r_cd_cnt <= w_cd_next;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oMove       = r_move;
  assign oMove_Valid = r_move_valid;
  assign oCand       = r_cand;
  assign oCount      = r_count;
  assign oBusy       = r_busy;

endmodule

// File: tb/tb_move_vote_filter.sv
// Directed bench for move_vote_filter: each task drives one scenario and checks outputs inline.
module tb_move_vote_filter;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [3:0] iLoc;
  logic       iInt;
  logic       iMove_Ack;
  logic [3:0] oMove;
  logic       oMove_Valid;
  logic [3:0] oCand;
  logic [3:0] oCount;
  logic       oBusy;

  int checks = 0;
  int errors = 0;

  move_vote_filter #(.HOLD_FRAMES(4), .COOLDOWN_FRAMES(8), .MAX_CELL(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iLoc(iLoc), .iInt(iInt), .iMove_Ack(iMove_Ack),
    .oMove(oMove), .oMove_Valid(oMove_Valid), .oCand(oCand), .oCount(oCount), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  task automatic apply_reset();
    @(negedge iCLK);
    iRST = 1'b1; iInt = 1'b0; iMove_Ack = 1'b0; iLoc = 4'd0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
  endtask

  // One detection: high for one cycle, low for one; returns at a negedge with outputs settled.
  task automatic pulse(input logic [3:0] l);
    @(negedge iCLK);
    iLoc = l; iInt = 1'b1;
    @(negedge iCLK);
    iInt = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic ack();
    @(negedge iCLK);
    iMove_Ack = 1'b1;
    @(negedge iCLK);
    iMove_Ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({oMove, oMove_Valid, oCand, oCount, oBusy} !== {4'd0, 1'b0, 4'hF, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got mv=%0d v=%0b cand=%0h cnt=%0d busy=%0b exp 0 0 f 0 0",
               oMove, oMove_Valid, oCand, oCount, oBusy);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    for (int i = 0; i < 3; i++) pulse(4'd5);
    checks++;
    if (oCount !== 4'd3 || oCand !== 4'd5) begin
      errors++; $display("FAIL basic_cnt3 got cnt=%0d cand=%0d exp 3 5", oCount, oCand);
    end
    @(negedge iCLK);
    iLoc = 4'd5; iInt = 1'b1;
    checks++;
    if (oMove_Valid !== 1'b0) begin
      errors++; $display("FAIL basic_early got v=%0b exp 0", oMove_Valid);
    end
    @(negedge iCLK);
    checks++;
    if (oMove_Valid !== 1'b1 || oMove !== 4'd5 || oBusy !== 1'b1 || oCount !== 4'd4) begin
      errors++;
      $display("FAIL basic_move got v=%0b mv=%0d busy=%0b cnt=%0d exp 1 5 1 4",
               oMove_Valid, oMove, oBusy, oCount);
    end
    iInt = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic test_restart();
    logic [3:0] locs [6] = '{4'd3, 4'd3, 4'd7, 4'd7, 4'd7, 4'd7};
    logic [3:0] cnts [6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd4};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      pulse(locs[i]);
      checks++;
      if (oCount !== cnts[i] || oCand !== locs[i] || oMove_Valid !== (i == 5)) begin
        errors++;
        $display("FAIL restart[%0d] got cnt=%0d cand=%0d v=%0b exp %0d %0d %0b",
                 i, oCount, oCand, oMove_Valid, cnts[i], locs[i], (i == 5));
      end
    end
    checks++;
    if (oMove !== 4'd7) begin
      errors++; $display("FAIL restart_move got %0d exp 7", oMove);
    end
  endtask

  task automatic test_invalid();
    apply_reset();
    pulse(4'd9);
    checks++;
    if (oCand !== 4'hF || oCount !== 4'd0) begin
      errors++; $display("FAIL inv_idle9 got cand=%0h cnt=%0d exp f 0", oCand, oCount);
    end
    pulse(4'd2); pulse(4'd2); pulse(4'd15);
    checks++;
    if (oCand !== 4'hF || oCount !== 4'd0 || oMove_Valid !== 1'b0) begin
      errors++;
      $display("FAIL inv_drop got cand=%0h cnt=%0d v=%0b exp f 0 0", oCand, oCount, oMove_Valid);
    end
    for (int i = 1; i <= 4; i++) begin
      pulse(4'd2);
      checks++;
      if (oCount !== 4'(i) || oMove_Valid !== (i == 4)) begin
        errors++;
        $display("FAIL inv_rebuild[%0d] got cnt=%0d v=%0b exp %0d %0b", i, oCount, oMove_Valid, i, (i == 4));
      end
    end
    checks++;
    if (oMove !== 4'd2) begin
      errors++; $display("FAIL inv_move got %0d exp 2", oMove);
    end
  endtask

  task automatic test_pend_hold();
    logic [3:0] noise [6] = '{4'd1, 4'd8, 4'd15, 4'd0, 4'd3, 4'd8};
    apply_reset();
    for (int i = 0; i < 4; i++) pulse(4'd8);
    for (int i = 0; i < 6; i++) begin
      pulse(noise[i]);
      checks++;
      if (oMove_Valid !== 1'b1 || oMove !== 4'd8 || oCount !== 4'd4 || oBusy !== 1'b1) begin
        errors++;
        $display("FAIL pend_hold[%0d] got v=%0b mv=%0d cnt=%0d busy=%0b exp 1 8 4 1",
                 i, oMove_Valid, oMove, oCount, oBusy);
      end
    end
    ack();
    checks++;
    if (oMove_Valid !== 1'b0 || oBusy !== 1'b1 || oCand !== 4'hF || oCount !== 4'd0) begin
      errors++;
      $display("FAIL pend_ack got v=%0b busy=%0b cand=%0h cnt=%0d exp 0 1 f 0",
               oMove_Valid, oBusy, oCand, oCount);
    end
    ack();
    checks++;
    if (oMove_Valid !== 1'b0 || oBusy !== 1'b1) begin
      errors++; $display("FAIL stray_ack got v=%0b busy=%0b exp 0 1", oMove_Valid, oBusy);
    end
  endtask

  task automatic test_cooldown();
    apply_reset();
    for (int i = 0; i < 4; i++) pulse(4'd1);
    @(negedge iCLK);
    iLoc = 4'd4; iInt = 1'b1; iMove_Ack = 1'b1;
    @(negedge iCLK);
    iInt = 1'b0; iMove_Ack = 1'b0;
    checks++;
    if (oMove_Valid !== 1'b0 || oBusy !== 1'b1) begin
      errors++; $display("FAIL cd_ack got v=%0b busy=%0b exp 0 1", oMove_Valid, oBusy);
    end
    @(negedge iCLK);
    for (int i = 1; i <= 8; i++) begin
      pulse(4'd4);
      checks++;
      if (oCount !== 4'd0 || oMove_Valid !== 1'b0 || oBusy !== (i < 8)) begin
        errors++;
        $display("FAIL cd_ignore[%0d] got cnt=%0d v=%0b busy=%0b exp 0 0 %0b",
                 i, oCount, oMove_Valid, oBusy, (i < 8));
      end
    end
    for (int i = 1; i <= 4; i++) begin
      pulse(4'd4);
      checks++;
      if (oCount !== 4'(i) || oMove_Valid !== (i == 4)) begin
        errors++;
        $display("FAIL cd_track[%0d] got cnt=%0d v=%0b exp %0d %0b", i, oCount, oMove_Valid, i, (i == 4));
      end
    end
    checks++;
    if (oMove !== 4'd4) begin
      errors++; $display("FAIL cd_move got %0d exp 4", oMove);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) pulse(4'd6);
    checks++;
    if (oCount !== 4'd3) begin
      errors++; $display("FAIL mid_pre got cnt=%0d exp 3", oCount);
    end
    @(negedge iCLK);
    iRST = 1'b1; iInt = 1'b1; iLoc = 4'd6;
    @(negedge iCLK);
    iRST = 1'b0;
    checks++;
    if ({oMove, oMove_Valid, oCand, oCount, oBusy} !== {4'd0, 1'b0, 4'hF, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_track_rst got mv=%0d v=%0b cand=%0h cnt=%0d busy=%0b exp 0 0 f 0 0",
               oMove, oMove_Valid, oCand, oCount, oBusy);
    end
    repeat (3) @(negedge iCLK);
    checks++;
    if (oCand !== 4'hF || oCount !== 4'd0) begin
      errors++; $display("FAIL mid_held_int got cand=%0h cnt=%0d exp f 0", oCand, oCount);
    end
    iInt = 1'b0;
    @(negedge iCLK);
    for (int i = 0; i < 4; i++) pulse(4'd6);
    checks++;
    if (oMove_Valid !== 1'b1 || oMove !== 4'd6) begin
      errors++; $display("FAIL mid_pend got v=%0b mv=%0d exp 1 6", oMove_Valid, oMove);
    end
    @(negedge iCLK);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    checks++;
    if ({oMove, oMove_Valid, oCand, oCount, oBusy} !== {4'd0, 1'b0, 4'hF, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_pend_rst got mv=%0d v=%0b cand=%0h cnt=%0d busy=%0b exp 0 0 f 0 0",
               oMove, oMove_Valid, oCand, oCount, oBusy);
    end
  endtask

  initial begin
    iRST = 1'b1; iInt = 1'b0; iLoc = 4'd0; iMove_Ack = 1'b0;
    test_reset();
    test_basic();
    test_restart();
    test_invalid();
    test_pend_hold();
    test_cooldown();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
